// File: rtl/ob_move.sv
// Obstacle mover: waits SPAWN_DELAY frames, spawns at the right edge with LFSR-chosen Y, slides left per frame.
// All outputs registered (one clk after the causing input); no backpressure, collision pre-empts movement and escape.
module ob_move #(
    parameter int          OBJECT_WIDTH_X  = 100,
    parameter int          OBJECT_HEIGHT_Y = 100,
    parameter int          SCREEN_W        = 640,
    parameter int          SCREEN_H        = 480,
    parameter int          SPAWN_DELAY     = 30,
    parameter int          HIT_FRAMES      = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               collision,
    input  logic [3:0]         speed,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               active,
    output logic               escaped,
    output logic               hit
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MOVE, S_HIT} state_t;

    localparam logic signed [10:0] START_X   = 11'(SCREEN_W);
    localparam logic        [9:0]  Y_RANGE   = 10'(SCREEN_H - OBJECT_HEIGHT_Y);
    localparam logic        [7:0]  SPAWN_CNT = 8'(SPAWN_DELAY);
    localparam logic        [7:0]  HIT_CNT   = 8'(HIT_FRAMES);
    localparam logic signed [12:0] WIDTH     = 13'(OBJECT_WIDTH_X);

    state_t              state, state_nxt;
    logic        [7:0]   cnt, cnt_nxt;
    logic signed [10:0]  x_nxt, y_nxt;
    logic                active_nxt, escaped_nxt, hit_nxt;
    logic        [15:0]  lfsr;
    logic                lfsr_fb;
    logic        [9:0]   y_raw, y_wrap;
    logic signed [10:0]  spawn_y;
    logic        [3:0]   step;
    logic signed [12:0]  moved, right_edge;
    logic                escape_now;

    // Maximal-length sequence from a nonzero seed, so the register never holds zero.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) lfsr <= LFSR_SEED;
        else         lfsr <= {lfsr[14:0], lfsr_fb};
    end

    assign y_raw   = {1'b0, lfsr[8:0]};
    assign y_wrap  = (y_raw >= Y_RANGE) ? (y_raw - Y_RANGE) : y_raw;
    assign spawn_y = $signed({1'b0, y_wrap});

    // Speed zero would park the obstacle forever, so it moves at least one pixel.
    assign step       = (speed == 4'd0) ? 4'd1 : speed;
    assign moved      = $signed({{2{topLeftX[10]}}, topLeftX}) - $signed({9'd0, step});
    assign right_edge = moved + WIDTH;
    assign escape_now = (right_edge <= 13'sd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            topLeftX <= START_X;
            topLeftY <= 11'sd0;
            active   <= 1'b0;
            escaped  <= 1'b0;
            hit      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            topLeftX <= x_nxt;
            topLeftY <= y_nxt;
            active   <= active_nxt;
            escaped  <= escaped_nxt;
            hit      <= hit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_WAIT;
                S_WAIT: if (startOfFrame && cnt == 8'd0) state_nxt = S_MOVE;
                S_MOVE: begin
                    if (collision)                       state_nxt = S_HIT;
                    else if (startOfFrame && escape_now) state_nxt = S_WAIT;
                end
                S_HIT:  if (startOfFrame && cnt <= 8'd1) state_nxt = S_WAIT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        x_nxt       = topLeftX;
        y_nxt       = topLeftY;
        cnt_nxt     = cnt;
        escaped_nxt = 1'b0;
        hit_nxt     = 1'b0;
        active_nxt  = (state_nxt == S_MOVE) || (state_nxt == S_HIT);
        if (!enable) begin
            x_nxt   = START_X;
            cnt_nxt = 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    x_nxt   = START_X;
                    cnt_nxt = SPAWN_CNT;
                end
                S_WAIT: begin
                    if (startOfFrame) begin
                        if (cnt == 8'd0) begin
                            x_nxt = START_X;
                            y_nxt = spawn_y;
                        end else begin
                            cnt_nxt = cnt - 8'd1;
                        end
                    end
                end
                S_MOVE: begin
                    if (collision) begin
                        hit_nxt = 1'b1;
                        cnt_nxt = HIT_CNT;
                    end else if (startOfFrame) begin
                        x_nxt = moved[10:0];
                        if (escape_now) begin
                            escaped_nxt = 1'b1;
                            cnt_nxt     = SPAWN_CNT;
                        end
                    end
                end
                S_HIT: begin
                    // The freeze lasts exactly HIT_FRAMES frames after the hit.
                    if (startOfFrame) begin
                        if (cnt <= 8'd1) begin
                            x_nxt   = START_X;
                            cnt_nxt = SPAWN_CNT;
                        end else begin
                            cnt_nxt = cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    x_nxt   = START_X;
                    cnt_nxt = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ob_move.sv
// Directed bench for ob_move with SPAWN_DELAY=2; spawn Y checked against a reference LFSR.
module tb_ob_move;
    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               enable = 1'b0;
    logic               collision = 1'b0;
    logic [3:0]         speed = 4'd0;
    logic signed [10:0] tlx, tly;
    logic               active, escaped, hit;
    int                 errors = 0;
    int                 checks = 0;
    logic [15:0]        m_lfsr, m_prev;

    always #5 clk = ~clk;

    ob_move #(.SPAWN_DELAY(2)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .collision(collision), .speed(speed), .topLeftX(tlx), .topLeftY(tly),
        .active(active), .escaped(escaped), .hit(hit)
    );

    // Reference generator; m_prev is the value the DUT saw at the most recent edge.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic int exp_y(input logic [15:0] v);
        int y;
        y = int'(v[8:0]);
        return (y >= 380) ? y - 380 : y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #12;
        checks++; if (tlx !== 11'sd640) begin errors++; $display("FAIL reset_x got %0d want 640", tlx); end
        checks++; if (tly !== 11'sd0) begin errors++; $display("FAIL reset_y got %0d want 0", tly); end
        checks++; if ({active, escaped, hit} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {active, escaped, hit}); end
        resetN = 1'b1;
        step();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_active got %b want 0", active); end
    endtask

    task automatic test_spawn();
        enable = 1'b1;
        step();
        frames(2);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL wait_active got %b want 0", active); end
        frame();
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL spawn_active got %b want 1", active); end
        checks++; if (tlx !== 11'sd640) begin errors++; $display("FAIL spawn_x got %0d want 640", tlx); end
        checks++; if (int'(tly) !== exp_y(m_prev) || tly < 0 || tly > 379) begin
            errors++; $display("FAIL spawn_y got %0d want %0d", tly, exp_y(m_prev)); end
    endtask

    task automatic test_move();
        speed = 4'd5;
        frames(10);
        checks++; if (tlx !== 11'sd590) begin errors++; $display("FAIL move_speed5 got %0d want 590", tlx); end
        speed = 4'd0;
        frames(3);
        checks++; if (tlx !== 11'sd587) begin errors++; $display("FAIL move_speed0 got %0d want 587", tlx); end
    endtask

    task automatic test_collision();
        speed = 4'd7;
        frames(41);
        checks++; if (tlx !== 11'sd300) begin errors++; $display("FAIL pre_hit_x got %0d want 300", tlx); end
        collision = 1'b1;
        frame();
        collision = 1'b0;
        checks++; if (tlx !== 11'sd300) begin errors++; $display("FAIL hit_x got %0d want 300", tlx); end
        checks++; if ({hit, escaped, active} !== 3'b101) begin errors++; $display("FAIL hit_flags got %b want 101", {hit, escaped, active}); end
        step();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_width got %b want 0", hit); end
        for (int i = 0; i < 7; i++) begin
            collision = 1'b1;
            frame();
            collision = 1'b0;
            checks++; if (hit !== 1'b0 || active !== 1'b1 || tlx !== 11'sd300) begin
                errors++; $display("FAIL hit_frozen frame %0d got hit=%b active=%b x=%0d want 0 1 300", i, hit, active, tlx); end
        end
        frame();
        checks++; if (active !== 1'b0 || tlx !== 11'sd640) begin
            errors++; $display("FAIL hit_end got active=%b x=%0d want 0 640", active, tlx); end
        collision = 1'b1;
        step();
        collision = 1'b0;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wait_collision got %b want 0", hit); end
    endtask

    task automatic test_escape();
        frames(3);
        checks++; if (active !== 1'b1 || tlx !== 11'sd640) begin
            errors++; $display("FAIL respawn got active=%b x=%0d want 1 640", active, tlx); end
        speed = 4'd15;
        frames(49);
        checks++; if (tlx !== -11'sd95 || escaped !== 1'b0) begin
            errors++; $display("FAIL near_edge got x=%0d esc=%b want -95 0", tlx, escaped); end
        speed = 4'd5;
        frame();
        checks++; if (tlx !== -11'sd100) begin errors++; $display("FAIL escape_x got %0d want -100", tlx); end
        checks++; if ({escaped, hit, active} !== 3'b100) begin errors++; $display("FAIL escape_flags got %b want 100", {escaped, hit, active}); end
        step();
        checks++; if (escaped !== 1'b0 || tlx !== -11'sd100) begin
            errors++; $display("FAIL escape_after got esc=%b x=%0d want 0 -100", escaped, tlx); end
    endtask

    task automatic test_priority();
        frames(3);
        speed = 4'd15;
        frames(49);
        speed = 4'd5;
        collision = 1'b1;
        frame();
        collision = 1'b0;
        checks++; if ({hit, escaped, active} !== 3'b101 || tlx !== -11'sd95) begin
            errors++; $display("FAIL collide_at_edge got flags=%b x=%0d want 101 -95", {hit, escaped, active}, tlx); end
        frames(8);
        checks++; if (active !== 1'b0 || tlx !== 11'sd640 || escaped !== 1'b0) begin
            errors++; $display("FAIL collide_at_edge_end got active=%b x=%0d esc=%b want 0 640 0", active, tlx, escaped); end
    endtask

    task automatic test_enable_drop();
        frames(3);
        frames(2);
        checks++; if (tlx !== 11'sd630) begin errors++; $display("FAIL drop_pre got %0d want 630", tlx); end
        enable = 1'b0;
        collision = 1'b1;
        step();
        collision = 1'b0;
        checks++; if (active !== 1'b0 || tlx !== 11'sd640 || hit !== 1'b0) begin
            errors++; $display("FAIL enable_drop got active=%b x=%0d hit=%b want 0 640 0", active, tlx, hit); end
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_hit();
        frames(3);
        collision = 1'b1;
        step();
        collision = 1'b0;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_hit_setup got %b want 1", hit); end
        resetN = 1'b0;
        #1;
        checks++; if (tlx !== 11'sd640 || tly !== 11'sd0 || {active, escaped, hit} !== 3'b000) begin
            errors++; $display("FAIL async_reset got x=%0d y=%0d flags=%b want 640 0 000", tlx, tly, {active, escaped, hit}); end
        #3;
        resetN = 1'b1;
        step();
        checks++; if ({active, escaped, hit} !== 3'b000 || tlx !== 11'sd640) begin
            errors++; $display("FAIL post_reset got flags=%b x=%0d want 000 640", {active, escaped, hit}, tlx); end
    endtask

    task automatic test_spawns();
        for (int i = 0; i < 1000; i++) begin
            enable = 1'b0;
            step();
            enable = 1'b1;
            step();
            for (int k = 0; k < i % 5; k++) step();
            frames(3);
            checks++; if (active !== 1'b1 || int'(tly) !== exp_y(m_prev) || tly < 0 || tly > 379) begin
                errors++; $display("FAIL spawn_%0d got y=%0d active=%b want y=%0d active=1", i, tly, active, exp_y(m_prev)); end
            checks++; if (dut.lfsr === 16'd0) begin
                errors++; $display("FAIL lfsr_nonzero_%0d got 0 want nonzero", i); end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spawn();
        test_move();
        test_collision();
        test_escape();
        test_priority();
        test_enable_drop();
        test_reset_mid_hit();
        test_spawns();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ob_move.md
OB_MOVE -- requirements
Module: ob_move

Interface
REQ-001 Parameter OBJECT_WIDTH_X, default 100, obstacle width in pixels.
REQ-002 Parameter OBJECT_HEIGHT_Y, default 100, obstacle height in pixels.
REQ-003 Parameter SCREEN_W, default 640, and SCREEN_H, default 480, visible area in pixels.
REQ-004 Parameter SPAWN_DELAY, default 30, frames waited before each spawn.
REQ-005 Parameter HIT_FRAMES, default 8, frames the obstacle is frozen after a collision.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, nonzero seed of the spawn-Y generator.
REQ-007 clk  in  1  system clock.
REQ-008 resetN  in  1  reset, asynchronous, active-low.
REQ-009 startOfFrame  in  1  one-clk pulse, once per VGA frame.
REQ-010 enable  in  1  game running; low parks the obstacle.
REQ-011 collision  in  1  one-clk pulse, obstacle hit by the player or a shot.
REQ-012 speed  in  4  pixels moved left per frame, unsigned.
REQ-013 topLeftX  out  11 signed  obstacle left edge, feeds the ob drawing stage.
REQ-014 topLeftY  out  11 signed  obstacle top edge, feeds the ob drawing stage.
REQ-015 active  out  1  high in MOVE and HIT.
REQ-016 escaped  out  1  one-clk pulse when the obstacle fully exits the left edge.
REQ-017 hit  out  1  one-clk pulse on an accepted collision.

Function
REQ-018 The block SHALL implement the states IDLE, WAIT, MOVE and HIT, with all outputs registered.
REQ-019 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk in every state; it SHALL never reach zero.
REQ-020 IDLE: topLeftX=SCREEN_W, active=0; enable high -> WAIT with frame counter loaded to SPAWN_DELAY.
REQ-021 WAIT: on each startOfFrame the counter SHALL decrement; on the startOfFrame that finds the counter at 0 -> MOVE.
REQ-022 On the WAIT->MOVE transition, topLeftX SHALL be set to SCREEN_W.
REQ-023 On the WAIT->MOVE transition, topLeftY SHALL be set to Y=lfsr[8:0], reduced to Y-(SCREEN_H-OBJECT_HEIGHT_Y) when Y>=SCREEN_H-OBJECT_HEIGHT_Y, so that 0<=topLeftY<380 at defaults.
REQ-024 MOVE: on startOfFrame, topLeftX SHALL become topLeftX-step, where step=speed and speed=0 is treated as 1; arithmetic is signed, at least 12 bits internally.
REQ-025 MOVE: if the new topLeftX+OBJECT_WIDTH_X<=0, escaped SHALL pulse one clk and the state SHALL go to WAIT with counter=SPAWN_DELAY; topLeftX SHALL hold that last value.
REQ-026 MOVE: collision -> HIT, hit pulses one clk, and position is frozen.
REQ-027 Collision SHALL take priority over movement and escape in the same clk.
REQ-028 Collision SHALL be ignored in IDLE, WAIT and HIT (no hit pulse).
REQ-029 HIT: the counter SHALL be loaded with HIT_FRAMES on entry and decremented per startOfFrame; at 0 -> WAIT with topLeftX=SCREEN_W and counter=SPAWN_DELAY.
REQ-030 enable low SHALL force IDLE on the next clk from any state and SHALL override all other events.
REQ-031 escaped and hit SHALL never be high in the same clk.

Reset
REQ-032 resetN low SHALL asynchronously set: state IDLE, topLeftX=SCREEN_W, topLeftY=0, active=0, escaped=0, hit=0, counter=0, lfsr=LFSR_SEED.
REQ-033 Reset asserted mid-MOVE or mid-HIT SHALL take effect immediately, with no residual pulse after release.

Verification
REQ-034 Reset, then enable=1, SPAWN_DELAY=2 -> MOVE on the 3rd startOfFrame; topLeftX=640, topLeftY<380, active=1.
REQ-035 MOVE with speed=5, 10 frames -> topLeftX=590; speed=0 for 3 frames -> topLeftX=587.
REQ-036 topLeftX=-95, speed=5, startOfFrame -> topLeftX=-100, escaped pulses 1 clk, state WAIT, active=0.
REQ-037 collision together with startOfFrame in MOVE at X=300 -> X stays 300, hit pulses once; 8 frames later -> WAIT and X=640; collisions during HIT produce no hit pulse.
REQ-038 enable dropped mid-MOVE -> IDLE next clk, X=640; resetN pulsed mid-HIT -> all outputs at reset values at once.
REQ-039 Run 1000 spawns -> every topLeftY lies in [0,379] and the LFSR never reads 0.
